// File: rtl/platform_scheduler.sv
// Frame-synchronous geometry scheduler: moves the hole and scrolls the platform
// row once per vsync falling edge, so every visible frame uses one geometry.
module platform_scheduler #(
  parameter int HOLE_WIDTH  = 64,
  parameter int HOLE_STEP   = 2,
  parameter int FRAME_DIV   = 2,
  parameter int PLAT_HEIGHT = 16,
  parameter int PLAT_INIT   = 400,
  parameter int SCROLL_STEP = 4,
  parameter int SCROLL_DIST = 96,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       scroll_req,
  input  logic       pause,
  output logic [9:0] plataform_start,
  output logic [9:0] plataform_end,
  output logic [9:0] hole_start,
  output logic [9:0] hole_end,
  output logic       scrolling,
  output logic       frame_tick
);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t        state;
  logic          vsync_d;
  logic          dir_left;
  logic          pending;
  logic [DW-1:0] div_cnt;
  logic [9:0]    scroll_cnt;

  logic [10:0] right_sum, plat_sum;
  logic [9:0]  hole_nxt, plat_nxt, cnt_nxt;
  logic        dir_nxt;
  logic        upd;

  assign upd = frame_tick & ~pause;

  // Hole bounces between the screen edges, clamping when the step would overshoot
  always_comb begin
    hole_nxt  = hole_start;
    dir_nxt   = dir_left;
    right_sum = {1'b0, hole_start} + 11'(HOLE_STEP + HOLE_WIDTH);
    if (dir_left) begin
      if (hole_start < 10'(HOLE_STEP)) begin
        hole_nxt = 10'd0;
        dir_nxt  = 1'b0;
      end else begin
        hole_nxt = hole_start - 10'(HOLE_STEP);
      end
    end else begin
      if (right_sum > 11'(SCREEN_W)) begin
        hole_nxt = 10'(SCREEN_W - HOLE_WIDTH);
        dir_nxt  = 1'b1;
      end else begin
        hole_nxt = hole_start + 10'(HOLE_STEP);
      end
    end
  end

  // Platform top wraps modulo screen height; the sum is kept 11 bits wide
  always_comb begin
    plat_sum = {1'b0, plataform_start} + 11'(SCROLL_STEP);
    plat_nxt = (plat_sum >= 11'(SCREEN_H)) ? 10'(plat_sum - 11'(SCREEN_H)) : plat_sum[9:0];
    cnt_nxt  = scroll_cnt + 10'(SCROLL_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      vsync_d         <= 1'b1;
      dir_left        <= 1'b0;
      pending         <= 1'b0;
      div_cnt         <= '0;
      scroll_cnt      <= '0;
      plataform_start <= 10'(PLAT_INIT);
      plataform_end   <= 10'(PLAT_INIT + PLAT_HEIGHT);
      hole_start      <= 10'd0;
      hole_end        <= 10'(HOLE_WIDTH);
      scrolling       <= 1'b0;
      frame_tick      <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= vsync_d & ~vsync;
      if (scroll_req) pending <= 1'b1;
      if (upd) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt    <= '0;
          hole_start <= hole_nxt;
          hole_end   <= hole_nxt + 10'(HOLE_WIDTH);
          dir_left   <= dir_nxt;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        case (state)
          IDLE: if (pending) begin
            state      <= SCROLL;
            scrolling  <= 1'b1;
            scroll_cnt <= '0;
            // a request landing on the arm edge itself stays queued
            pending    <= scroll_req;
          end
          SCROLL: begin
            plataform_start <= plat_nxt;
            plataform_end   <= plat_nxt + 10'(PLAT_HEIGHT);
            scroll_cnt      <= cnt_nxt;
            if (cnt_nxt == 10'(SCROLL_DIST)) begin
              state     <= IDLE;
              scrolling <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
